// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter in front of a 1R/1W word memory; optional perf counters under MEM_ARB_PERF_EN
module mem_arbiter #(
  parameter int NUMWORDS  = 4096,
  parameter int DATAWIDTH = 32,
  parameter int AW        = $clog2(NUMWORDS) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_req_i,
  input  logic [AW-1:0]        i_addr_i,
  output logic                 i_gnt_o,
  output logic                 i_rvalid_o,
  output logic [DATAWIDTH-1:0] i_rdata_o,
  input  logic                 d_req_i,
  input  logic                 d_we_i,
  input  logic [AW-1:0]        d_addr_i,
  input  logic [DATAWIDTH-1:0] d_wdata_i,
  output logic                 d_gnt_o,
  output logic                 d_rvalid_o,
  output logic [DATAWIDTH-1:0] d_rdata_o,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]          conflict_cnt_o,
  output logic [31:0]          i_stall_cnt_o,
`endif
  output logic                 mem_re_o,
  output logic [AW-1:0]        mem_raddr_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_waddr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o
);

  // rr_q = 1 means D wins the next read conflict, 0 means I wins
  logic                 rr_q, rr_d;
  logic                 i_rvalid_q, i_rvalid_d;
  logic [DATAWIDTH-1:0] i_rdata_q, i_rdata_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic [DATAWIDTH-1:0] d_rdata_q, d_rdata_d;

  logic read_i, read_d, write_d, conflict, d_rgnt;

  // Arbitration, memory port steering and next-state of the response registers
  always_comb begin
    read_i   = i_req_i;
    read_d   = d_req_i & ~d_we_i;
    write_d  = d_req_i & d_we_i;
    conflict = read_i & read_d;

    i_gnt_o  = read_i & (~read_d | ~rr_q);
    d_rgnt   = read_d & (~read_i | rr_q);
    d_gnt_o  = write_d | d_rgnt;

    // Loser of a conflict becomes the preferred requester
    rr_d     = conflict ? ~rr_q : rr_q;

    mem_re_o    = read_i | read_d;
    mem_raddr_o = '0;
    if (i_gnt_o) begin
      mem_raddr_o = i_addr_i;
    end else if (d_rgnt) begin
      mem_raddr_o = d_addr_i;
    end

    mem_we_o    = write_d;
    mem_waddr_o = write_d ? d_addr_i  : '0;
    mem_wdata_o = write_d ? d_wdata_i : '0;

    i_rvalid_d = i_gnt_o;
    i_rdata_d  = i_gnt_o ? mem_rdata_i : i_rdata_q;

    d_rvalid_d = d_gnt_o;
    d_rdata_d  = d_rdata_q;
    if (write_d) begin
      d_rdata_d = '0;
    end else if (d_rgnt) begin
      d_rdata_d = mem_rdata_i;
    end
  end

  // Response and arbitration state; async reset drops any in-flight response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= 1'b1;
      i_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      rr_q       <= rr_d;
      i_rvalid_q <= i_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign i_rvalid_o = i_rvalid_q;
  assign i_rdata_o  = i_rdata_q;
  assign d_rvalid_o = d_rvalid_q;
  assign d_rdata_o  = d_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic [31:0] i_stall_cnt_q, i_stall_cnt_d;

  // Free-running wrap-around event counters
  always_comb begin
    conflict_cnt_d = conflict_cnt_q + {31'd0, conflict};
    i_stall_cnt_d  = i_stall_cnt_q + {31'd0, (i_req_i & ~i_gnt_o)};
  end

  // Counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
      i_stall_cnt_q  <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      i_stall_cnt_q  <= i_stall_cnt_d;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign i_stall_cnt_o  = i_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a behavioural reference model
module tb_mem_arbiter;
  localparam int NW = 4096;
  localparam int DW = 32;
  localparam int AW = $clog2(NW) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] i_rdata, d_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_rdata, mem_wdata;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   conflict_cnt, i_stall_cnt;
`endif

  mem_arbiter #(.NUMWORDS(NW), .DATAWIDTH(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
`ifdef MEM_ARB_PERF_EN
    .conflict_cnt_o(conflict_cnt), .i_stall_cnt_o(i_stall_cnt),
`endif
    .mem_re_o(mem_re), .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
    .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read with write-through bypass
  logic [DW-1:0] env_mem [NW];
  assign mem_rdata = (mem_we && mem_waddr == mem_raddr) ? mem_wdata : env_mem[mem_raddr[11:0]];
  always @(posedge clk) if (mem_we) env_mem[mem_waddr[11:0]] <= mem_wdata;

  // Reference model state
  logic [DW-1:0] ref_mem [NW];
  bit            m_pref_d;
  logic [DW-1:0] m_ird, m_drd;
  int unsigned   m_conf, m_stall;

  // Observed / expected values of the last step
  logic          o_ig, o_dg, o_re, o_irv, o_drv;
  logic [DW-1:0] o_ird, o_drd;
  logic          e_ig, e_dg, e_re, e_irv, e_drv;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic model_reset();
    m_pref_d = 1'b1;
    m_ird = '0;
    m_drd = '0;
    m_conf = 0;
    m_stall = 0;
  endtask

  // Drive one cycle of requests (called at posedge+1), predict and observe
  task automatic step(input logic ir, input logic [AW-1:0] ia, input logic dr,
                      input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit rd_i, rd_d, wr, d_rd_win;
    logic [DW-1:0] i_val, d_val;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    rd_i = ir; rd_d = dr & ~dw; wr = dr & dw;
    if (rd_i && rd_d) begin
      e_ig = !m_pref_d;
      d_rd_win = m_pref_d;
      m_pref_d = !m_pref_d;
      m_conf++;
    end else begin
      e_ig = rd_i;
      d_rd_win = rd_d;
    end
    if (ir && !e_ig) m_stall++;
    e_dg = wr | d_rd_win;
    e_re = rd_i | rd_d;
    i_val = (wr && da == ia) ? dd : ref_mem[ia[11:0]];
    d_val = ref_mem[da[11:0]];
    e_irv = e_ig;
    e_drv = e_dg;
    if (e_ig) m_ird = i_val;
    if (wr) m_drd = '0;
    else if (d_rd_win) m_drd = d_val;
    if (wr) ref_mem[da[11:0]] = dd;
    #1;
    o_ig = i_gnt; o_dg = d_gnt; o_re = mem_re;
    @(posedge clk); #1;
    o_irv = i_rvalid; o_ird = i_rdata; o_drv = d_rvalid; o_drd = d_rdata;
  endtask

  task automatic idle_inputs();
    i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    i_req = 1; d_req = 1; d_we = 0; i_addr = 13'd1; d_addr = 13'd2; d_wdata = '1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (i_rvalid !== 1'b0) $display("FAIL reset_i_rvalid got %0b exp 0", i_rvalid); else pass_cnt++;
    total_cnt++; if (i_rdata !== '0) $display("FAIL reset_i_rdata got %h exp 0", i_rdata); else pass_cnt++;
    total_cnt++; if (d_rvalid !== 1'b0) $display("FAIL reset_d_rvalid got %0b exp 0", d_rvalid); else pass_cnt++;
    total_cnt++; if (d_rdata !== '0) $display("FAIL reset_d_rdata got %h exp 0", d_rdata); else pass_cnt++;
    idle_inputs();
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, '0, 0, 0, '0, '0);
      total_cnt++; if (o_irv !== 1'b0 || o_drv !== 1'b0)
        $display("FAIL post_reset_rvalid cyc %0d got i=%0b d=%0b exp 0", k, o_irv, o_drv); else pass_cnt++;
      total_cnt++; if (o_re !== 1'b0) $display("FAIL idle_mem_re got %0b exp 0", o_re); else pass_cnt++;
    end
  endtask

  task automatic test_single_i_read();
    env_mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
    step(1, 13'd5, 0, 0, '0, '0);
    total_cnt++; if (o_ig !== 1'b1) $display("FAIL single_i_gnt got %0b exp 1", o_ig); else pass_cnt++;
    total_cnt++; if (o_irv !== 1'b1) $display("FAIL single_i_rvalid got %0b exp 1", o_irv); else pass_cnt++;
    total_cnt++; if (o_ird !== 32'hDEADBEEF) $display("FAIL single_i_rdata got %h exp deadbeef", o_ird); else pass_cnt++;
    step(0, '0, 0, 0, '0, '0);
    total_cnt++; if (o_irv !== 1'b0 || o_ird !== 32'hDEADBEEF)
      $display("FAIL single_i_hold got v=%0b d=%h exp v=0 d=deadbeef", o_irv, o_ird); else pass_cnt++;
  endtask

  task automatic test_read_conflict();
    logic [3:0] exp_d = 4'b0101;
    do_reset();
    env_mem[1] = 32'h1111_0001; ref_mem[1] = 32'h1111_0001;
    env_mem[2] = 32'h2222_0002; ref_mem[2] = 32'h2222_0002;
    for (int k = 0; k < 4; k++) begin
      step(1, 13'd1, 1, 0, 13'd2, '0);
      total_cnt++; if (o_dg !== exp_d[k] || o_ig !== !exp_d[k])
        $display("FAIL conflict_gnt cyc %0d got d=%0b i=%0b exp d=%0b", k, o_dg, o_ig, exp_d[k]); else pass_cnt++;
      total_cnt++; if (o_drv !== e_drv || o_irv !== e_irv || o_drd !== m_drd || o_ird !== m_ird)
        $display("FAIL conflict_rsp cyc %0d got dv=%0b iv=%0b dd=%h id=%h exp dv=%0b iv=%0b dd=%h id=%h",
                 k, o_drv, o_irv, o_drd, o_ird, e_drv, e_irv, m_drd, m_ird); else pass_cnt++;
    end
`ifdef MEM_ARB_PERF_EN
    total_cnt++; if (conflict_cnt !== 32'd4) $display("FAIL conflict_cnt got %0d exp 4", conflict_cnt); else pass_cnt++;
    total_cnt++; if (i_stall_cnt !== 32'd2) $display("FAIL i_stall_cnt got %0d exp 2", i_stall_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_write_bypass();
    step(1, 13'd7, 1, 1, 13'd7, 32'h12345678);
    total_cnt++; if (o_ig !== 1'b1 || o_dg !== 1'b1)
      $display("FAIL bypass_gnt got i=%0b d=%0b exp 1 1", o_ig, o_dg); else pass_cnt++;
    total_cnt++; if (o_ird !== 32'h12345678 || o_irv !== 1'b1)
      $display("FAIL bypass_i_rdata got v=%0b d=%h exp v=1 d=12345678", o_irv, o_ird); else pass_cnt++;
    total_cnt++; if (o_drv !== 1'b1 || o_drd !== '0)
      $display("FAIL bypass_d_rsp got v=%0b d=%h exp v=1 d=0", o_drv, o_drd); else pass_cnt++;
    step(1, 13'd7, 0, 0, '0, '0);
    total_cnt++; if (o_ird !== 32'h12345678) $display("FAIL reread_addr7 got %h exp 12345678", o_ird); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(0, '0, 1, 1, 13'd3, 32'hA5A5A5A5);
    total_cnt++; if (o_drv !== 1'b1 || o_drd !== '0)
      $display("FAIL b2b_write_rsp got v=%0b d=%h exp v=1 d=0", o_drv, o_drd); else pass_cnt++;
    step(0, '0, 1, 0, 13'd3, '0);
    total_cnt++; if (o_drv !== 1'b1 || o_drd !== 32'hA5A5A5A5)
      $display("FAIL b2b_read_rsp got v=%0b d=%h exp v=1 d=a5a5a5a5", o_drv, o_drd); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    step(0, '0, 1, 0, 13'd3, '0);
    total_cnt++; if (o_drv !== 1'b1) $display("FAIL mid_pre_rvalid got %0b exp 1", o_drv); else pass_cnt++;
    idle_inputs();
    rst_n = 0;
    #1;
    total_cnt++; if (d_rvalid !== 1'b0) $display("FAIL mid_reset_rvalid got %0b exp 0", d_rvalid); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    step(0, '0, 0, 0, '0, '0);
    total_cnt++; if (o_drv !== 1'b0 || o_irv !== 1'b0)
      $display("FAIL mid_post_rvalid got d=%0b i=%0b exp 0 0", o_drv, o_irv); else pass_cnt++;
    step(1, 13'd1, 1, 0, 13'd2, '0);
    total_cnt++; if (o_dg !== 1'b1 || o_ig !== 1'b0)
      $display("FAIL mid_conflict_gnt got d=%0b i=%0b exp d=1 i=0", o_dg, o_ig); else pass_cnt++;
  endtask

  task automatic test_random();
    logic ir = 0, dr = 0, dw = 0;
    logic [AW-1:0] ia = '0, da = '0;
    logic [DW-1:0] dd = '0;
    bit pend_i = 0, pend_d = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (!pend_i) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 13'($urandom_range(0, 15));
      end
      if (!pend_d) begin
        dr = ($urandom_range(0, 3) != 0);
        dw = $urandom_range(0, 1);
        da = 13'($urandom_range(0, 15));
        dd = $urandom;
      end
      step(ir, ia, dr, dw, da, dd);
      pend_i = ir & ~o_ig;
      pend_d = dr & ~o_dg;
      total_cnt++; if (o_ig !== e_ig || o_dg !== e_dg || o_re !== e_re)
        $display("FAIL rand_gnt cyc %0d got ig=%0b dg=%0b re=%0b exp ig=%0b dg=%0b re=%0b",
                 k, o_ig, o_dg, o_re, e_ig, e_dg, e_re); else pass_cnt++;
      total_cnt++; if (o_irv !== e_irv || o_ird !== m_ird || o_drv !== e_drv || o_drd !== m_drd)
        $display("FAIL rand_rsp cyc %0d got iv=%0b id=%h dv=%0b dd=%h exp iv=%0b id=%h dv=%0b dd=%h",
                 k, o_irv, o_ird, o_drv, o_drd, e_irv, m_ird, e_drv, m_drd); else pass_cnt++;
    end
`ifdef MEM_ARB_PERF_EN
    total_cnt++; if (conflict_cnt !== m_conf || i_stall_cnt !== m_stall)
      $display("FAIL rand_perf got c=%0d s=%0d exp c=%0d s=%0d", conflict_cnt, i_stall_cnt, m_conf, m_stall); else pass_cnt++;
`endif
  endtask

  initial begin
    for (int a = 0; a < NW; a++) begin
      env_mem[a] = '0;
      ref_mem[a] = '0;
    end
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_single_i_read();
    test_read_conflict();
    test_write_bypass();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
